// File: rtl/demux_dispatcher.sv
// demux_dispatcher: round-robin valid/ready dispatcher feeding a 1-to-4 demux, skipping disabled channels.
module demux_dispatcher #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       chan_en,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [1:0]       sel_out,
  output logic             busy
`ifdef DEMUX_STATS_EN
  , input  logic             stats_clr
  , output logic [4*CNT_W-1:0] stat_count
`endif
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t r_state, w_next;
  logic [1:0] r_rr_ptr, r_sel, w_base, w_pick;
  logic [WIDTH-1:0] r_data;
  logic w_xfer, w_acc;
  assign w_xfer = (r_state == HOLD) && out_ready[r_sel];
  assign w_base = (r_state == HOLD) ? r_sel + 2'd1 : r_rr_ptr;
  always_comb begin
    w_pick = w_base;
    for (int k = 3; k >= 0; k--)
      if (chan_en[w_base + 2'(k)]) w_pick = w_base + 2'(k);
  end
  always_comb begin
    in_ready = !reset && (|chan_en) && (r_state == IDLE || out_ready[r_sel]);
    w_acc = in_valid && in_ready;
    w_next = w_acc ? HOLD : (w_xfer ? IDLE : r_state);
  end
  always_ff @(posedge clk)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (reset) begin
      r_rr_ptr <= '0;
      r_sel <= '0;
      r_data <= '0;
    end else begin
      if (w_xfer) r_rr_ptr <= r_sel + 2'd1;
      if (w_acc) begin
        r_data <= in_data;
        r_sel <= w_pick;
      end
    end
  assign out_valid = (r_state == HOLD) ? 4'd1 << r_sel : 4'd0;
  assign out_data = r_data;
  assign sel_out = r_sel;
  assign busy = (r_state == HOLD);
`ifdef DEMUX_STATS_EN
  for (genvar i = 0; i < 4; i++) begin : g_stat
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk)
      if (reset || stats_clr) r_cnt <= '0;
      else if (w_xfer && r_sel == 2'(i) && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    assign stat_count[i*CNT_W +: CNT_W] = r_cnt;
  end
`endif
endmodule
